mem_arbiter: RTL

- Sits between the instruction-fetch unit (IF), the load/store buffer (LSB) and the byte-serial memory controller's single request port.
- Latches one pending request per requester and issues one transaction at a time, with data-first priority plus an anti-starvation guard for fetch.
- Returns results to the correct requester.
- Handles flush (branch mispredict): cancels pending or in-flight fetches without disturbing data traffic.

---
 rtl/mem_arbiter.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-serial memory controller port between fetch and the LSB.
// Optional anti-starvation guard for fetch: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_r_nw,
    input  logic [1:0]  ls_size,
    input  logic        ls_sign,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        mc_valid,
    output logic        mc_r_nw,
    output logic [1:0]  mc_size,
    output logic        mc_sign,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_wdata,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_IF_BUSY = 2'd1;
    localparam logic [1:0] S_LS_BUSY = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [1:0]  state_q, state_d;
    logic        if_pend_q, if_pend_d;
    logic [31:0] if_addr_q, if_addr_d;
    logic        ls_pend_q, ls_pend_d;
    logic        ls_r_nw_q, ls_r_nw_d;
    logic [1:0]  ls_size_q, ls_size_d;
    logic        ls_sign_q, ls_sign_d;
    logic [31:0] ls_addr_q, ls_addr_d;
    logic [31:0] ls_wdata_q, ls_wdata_d;

    logic        mc_valid_q, mc_valid_d;
    logic        mc_r_nw_q, mc_r_nw_d;
    logic [1:0]  mc_size_q, mc_size_d;
    logic        mc_sign_q, mc_sign_d;
    logic [31:0] mc_addr_q, mc_addr_d;
    logic [31:0] mc_wdata_q, mc_wdata_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic        if_cand;
    logic        ls_cand;
    logic        arb_en;
    logic        grant_ls;
    logic        grant_if;
    logic        guard_fire;

    // A fresh pulse counts as a candidate; flush kills any fetch candidate.
    assign if_cand  = !flush && (if_req || if_pend_q);
    assign ls_cand  = ls_req || ls_pend_q;
    assign arb_en   = (state_q == S_IDLE) || mc_done;
    assign grant_ls = arb_en && ls_cand && !guard_fire;
    assign grant_if = arb_en && if_cand && !grant_ls;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             if_any;

    // Counter tracks LSB wins while fetch waits; flush does not touch it.
    assign if_any     = if_req || if_pend_q;
    assign guard_fire = (cnt_q == LIMIT) && if_cand;

    // Starvation counter next state.
    always_comb begin
        cnt_d = cnt_q;
        if (grant_if || !if_any) begin
            cnt_d = '0;
        end else if (grant_ls && cnt_q != LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (rdy) begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_lim;

    assign guard_fire = 1'b0;
    assign unused_lim = ^LIMIT;
`endif

    // Pending slots, arbitration, issue and completion routing.
    always_comb begin
        state_d    = state_q;
        if_pend_d  = if_pend_q;
        if_addr_d  = if_addr_q;
        ls_pend_d  = ls_pend_q;
        ls_r_nw_d  = ls_r_nw_q;
        ls_size_d  = ls_size_q;
        ls_sign_d  = ls_sign_q;
        ls_addr_d  = ls_addr_q;
        ls_wdata_d = ls_wdata_q;
        mc_valid_d = mc_valid_q;
        mc_r_nw_d  = mc_r_nw_q;
        mc_size_d  = mc_size_q;
        mc_sign_d  = mc_sign_q;
        mc_addr_d  = mc_addr_q;
        mc_wdata_d = mc_wdata_q;
        if_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_done_d  = 1'b0;
        ls_rdata_d = ls_rdata_q;

        if (if_req) begin
            if_pend_d = 1'b1;
            if_addr_d = if_addr;
        end
        if (flush || grant_if) begin
            if_pend_d = 1'b0;
        end

        if (ls_req) begin
            ls_pend_d  = 1'b1;
            ls_r_nw_d  = ls_r_nw;
            ls_size_d  = ls_size;
            ls_sign_d  = ls_sign;
            ls_addr_d  = ls_addr;
            ls_wdata_d = ls_wdata;
        end
        if (grant_ls) begin
            ls_pend_d = 1'b0;
        end

        if (state_q == S_IF_BUSY && mc_done && !flush) begin
            if_done_d = 1'b1;
            if_data_d = mc_rdata;
        end
        if (state_q == S_LS_BUSY && mc_done) begin
            ls_done_d  = 1'b1;
            ls_rdata_d = mc_rdata;
        end

        if (arb_en) begin
            unique case (1'b1)
                grant_ls: begin
                    state_d    = S_LS_BUSY;
                    mc_valid_d = 1'b1;
                    mc_r_nw_d  = ls_req ? ls_r_nw  : ls_r_nw_q;
                    mc_size_d  = ls_req ? ls_size  : ls_size_q;
                    mc_sign_d  = ls_req ? ls_sign  : ls_sign_q;
                    mc_addr_d  = ls_req ? ls_addr  : ls_addr_q;
                    mc_wdata_d = ls_req ? ls_wdata : ls_wdata_q;
                end
                grant_if: begin
                    state_d    = S_IF_BUSY;
                    mc_valid_d = 1'b1;
                    mc_r_nw_d  = 1'b1;
                    mc_size_d  = 2'd3;
                    mc_sign_d  = 1'b0;
                    mc_addr_d  = if_req ? if_addr : if_addr_q;
                    mc_wdata_d = '0;
                end
                default: begin
                    state_d    = S_IDLE;
                    mc_valid_d = 1'b0;
                end
            endcase
        end else if (state_q == S_IF_BUSY && flush) begin
            state_d = S_DRAIN;
        end
    end

    // State, slot and output registers; everything freezes while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            if_pend_q  <= 1'b0;
            if_addr_q  <= '0;
            ls_pend_q  <= 1'b0;
            ls_r_nw_q  <= 1'b0;
            ls_size_q  <= '0;
            ls_sign_q  <= 1'b0;
            ls_addr_q  <= '0;
            ls_wdata_q <= '0;
            mc_valid_q <= 1'b0;
            mc_r_nw_q  <= 1'b0;
            mc_size_q  <= '0;
            mc_sign_q  <= 1'b0;
            mc_addr_q  <= '0;
            mc_wdata_q <= '0;
            if_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_done_q  <= 1'b0;
            ls_rdata_q <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            if_pend_q  <= if_pend_d;
            if_addr_q  <= if_addr_d;
            ls_pend_q  <= ls_pend_d;
            ls_r_nw_q  <= ls_r_nw_d;
            ls_size_q  <= ls_size_d;
            ls_sign_q  <= ls_sign_d;
            ls_addr_q  <= ls_addr_d;
            ls_wdata_q <= ls_wdata_d;
            mc_valid_q <= mc_valid_d;
            mc_r_nw_q  <= mc_r_nw_d;
            mc_size_q  <= mc_size_d;
            mc_sign_q  <= mc_sign_d;
            mc_addr_q  <= mc_addr_d;
            mc_wdata_q <= mc_wdata_d;
            if_done_q  <= if_done_d;
            if_data_q  <= if_data_d;
            ls_done_q  <= ls_done_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign mc_valid = mc_valid_q;
    assign mc_r_nw  = mc_r_nw_q;
    assign mc_size  = mc_size_q;
    assign mc_sign  = mc_sign_q;
    assign mc_addr  = mc_addr_q;
    assign mc_wdata = mc_wdata_q;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

endmodule
